imm_encoder: RTL and testbench

- Inverse of the immediate generator: takes a 32-bit immediate value, an ImmSrc type and register fields, and packs them into instruction bits [31:7].
- Checks that the immediate fits the selected format before packing.
- Used by the instruction-assembly and self-test path of the single-cycle core, to build encodings that are then fed to the decode path.
- Valid/ready on both sides; multi-cycle FSM; saturating error counter.

---
 rtl/imm_encoder.sv | 155 +++++++++++++++
 tb/tb_imm_encoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// Immediate encoder: packs a 32-bit immediate plus register fields into instruction bits [31:7].
// Optional macro ROUNDTRIP_CHECK_EN adds a re-decode comparator and the rt_mismatch output.
module imm_encoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          imm,
  input  logic [2:0]           ImmSrc,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [2:0]           funct3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [24:0]          enc,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [ERR_CNT_W-1:0] err_cnt
`ifdef ROUNDTRIP_CHECK_EN
  ,
  output logic                 rt_mismatch
`endif
);

  localparam logic [2:0] SRC_I = 3'd0;
  localparam logic [2:0] SRC_S = 3'd1;
  localparam logic [2:0] SRC_B = 3'd2;
  localparam logic [2:0] SRC_U = 3'd3;
  localparam logic [2:0] SRC_J = 3'd4;

  typedef enum logic [1:0] {IDLE, CHECK, HOLD} stateT;

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  src;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
  } reqT;

  stateT state;
  reqT   req;

  logic        misaligned, outOfRange, illegalSrc;
  logic [1:0]  codeNext;
  logic [24:0] encPack;

  // Format check and packing work from the registered request only.
  always_comb begin
    illegalSrc = 1'b0;
    misaligned = 1'b0;
    outOfRange = 1'b0;
    encPack    = '0;
    case (req.src)
      SRC_I: begin
        outOfRange = !((&req.imm[31:11]) || !(|req.imm[31:11]));
        encPack    = {req.imm[11:0], req.rs1, req.f3, req.rd};
      end
      SRC_S: begin
        outOfRange = !((&req.imm[31:11]) || !(|req.imm[31:11]));
        encPack    = {req.imm[11:5], req.rs2, req.rs1, req.f3, req.imm[4:0]};
      end
      SRC_B: begin
        misaligned = req.imm[0];
        outOfRange = !((&req.imm[31:12]) || !(|req.imm[31:12]));
        encPack    = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.f3,
                      req.imm[4:1], req.imm[11]};
      end
      SRC_U: begin
        misaligned = |req.imm[11:0];
        encPack    = {req.imm[31:12], req.rd};
      end
      SRC_J: begin
        misaligned = req.imm[0];
        outOfRange = !((&req.imm[31:20]) || !(|req.imm[31:20]));
        encPack    = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12], req.rd};
      end
      default: illegalSrc = 1'b1;
    endcase
    codeNext = illegalSrc ? 2'b11 :
               misaligned ? 2'b10 :
               outOfRange ? 2'b01 : 2'b00;
  end

`ifdef ROUNDTRIP_CHECK_EN
  logic [31:0] instr, immBack;
  logic        rtNext;

  // Decode the packed word the same way the immediate generator does.
  always_comb begin
    instr   = {encPack, 7'b0};
    immBack = '0;
    rtNext  = 1'b0;
    case (req.src)
      SRC_I: immBack = {{20{instr[31]}}, instr[31:20]};
      SRC_S: immBack = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      SRC_B: immBack = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      SRC_U: immBack = {instr[31:12], 12'b0};
      SRC_J: immBack = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: immBack = '0;
    endcase
    if (codeNext == 2'b00)
      rtNext = (req.src == SRC_U) ? (immBack[31:12] != req.imm[31:12]) : (immBack != req.imm);
  end

  always @(posedge clk)
    if (rst_n && state == CHECK)
      assert (!rtNext) else $error("imm_encoder: round-trip mismatch on legal request");

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)              rt_mismatch <= 1'b0;
    else if (state == CHECK) rt_mismatch <= rtNext;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      enc       <= '0;
      err       <= 1'b0;
      err_code  <= 2'b00;
      err_cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          req      <= '{imm: imm, src: ImmSrc, rd: rd, rs1: rs1, rs2: rs2, f3: funct3};
          in_ready <= 1'b0;
          state    <= CHECK;
        end
        CHECK: begin
          enc       <= (codeNext == 2'b00) ? encPack : '0;
          err       <= (codeNext != 2'b00);
          err_code  <= codeNext;
          out_valid <= 1'b1;
          if (codeNext != 2'b00 && !(&err_cnt))
            err_cnt <= err_cnt + ERR_CNT_W'(1);
          state     <= HOLD;
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: reference model of the encoding rules, per-cycle compare, literal pins.
module tb_imm_encoder;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] imm = '0;
  logic [2:0]  ImmSrc = '0, funct3 = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic        in_ready, out_valid, err;
  logic [24:0] enc;
  logic [1:0]  err_code;
  logic [7:0]  err_cnt;
`ifdef ROUNDTRIP_CHECK_EN
  logic        rt_mismatch;
`endif

  imm_encoder #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .imm(imm), .ImmSrc(ImmSrc), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .out_valid(out_valid), .out_ready(out_ready), .enc(enc), .err(err),
    .err_code(err_code), .err_cnt(err_cnt)
`ifdef ROUNDTRIP_CHECK_EN
    , .rt_mismatch(rt_mismatch)
`endif
  );

  always #5 clk = ~clk;

  int          total = 0, passed = 0;
  logic [24:0] expEnc = '0;
  logic [1:0]  expCode = '0;
  int          expCnt = 0;
  bit          cmpEn = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: range by signed arithmetic, packing by placing fields into a full instruction word.
  function automatic logic [26:0] model(input logic [31:0] i, input logic [2:0] s,
      input logic [4:0] d, input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f);
    longint v = longint'($signed(i));
    logic [1:0]  code;
    logic [31:0] w = '0;
    bit inRange;
    case (s)
      3'd0, 3'd1: inRange = (v >= -2048) && (v <= 2047);
      3'd2:       inRange = (v >= -4096) && (v <= 4095);
      3'd4:       inRange = (v >= -(64'sd1 << 20)) && (v <= (64'sd1 << 20) - 1);
      default:    inRange = 1'b1;
    endcase
    if (s > 3'd4) code = 2'b11;
    else if (((s == 3'd2 || s == 3'd4) && i[0]) || (s == 3'd3 && i[11:0] != 0)) code = 2'b10;
    else if (!inRange) code = 2'b01;
    else code = 2'b00;
    w[11:7] = d; w[14:12] = f; w[19:15] = r1; w[24:20] = r2;
    case (s)
      3'd0: w[31:20] = i[11:0];
      3'd1: begin w[31:25] = i[11:5]; w[11:7] = i[4:0]; end
      3'd2: begin w[31] = i[12]; w[30:25] = i[10:5]; w[11:8] = i[4:1]; w[7] = i[11]; end
      3'd3: w[31:12] = i[31:12];
      default: begin w[31] = i[20]; w[30:21] = i[10:1]; w[20] = i[11]; w[19:12] = i[19:12]; end
    endcase
    return {code, (code == 2'b00) ? w[31:7] : 25'd0};
  endfunction

  always @(negedge clk)
    if (cmpEn && rst_n && out_valid) begin
      check("enc", 32'(enc), 32'(expEnc));
      check("err", 32'(err), 32'(expCode != 2'b00));
      check("err_code", 32'(err_code), 32'(expCode));
      check("err_cnt", 32'(err_cnt), 32'(expCnt));
      check("in_ready_hold", 32'(in_ready), 32'd0);
    end

  task automatic send(input logic [31:0] i, input logic [2:0] s, input logic [4:0] d,
      input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f, input int hold,
      output logic [24:0] got, output logic [1:0] gotCode);
    logic [26:0] m;
    int guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    imm = i; ImmSrc = s; rd = d; rs1 = r1; rs2 = r2; funct3 = f; in_valid = 1'b1;
    m = model(i, s, d, r1, r2, f);
    @(posedge clk); #1;
    in_valid = 1'b0;
    imm = $urandom; ImmSrc = 3'($urandom); rd = 5'($urandom); rs1 = 5'($urandom);
    rs2 = 5'($urandom); funct3 = 3'($urandom);
    expEnc = m[24:0]; expCode = m[26:25];
    if (expCode != 2'b00 && expCnt < 255) expCnt++;
    cmpEn = 1'b1;
    @(negedge clk);
    check("lat1_out_valid", 32'(out_valid), 32'd0);
    check("lat1_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("lat2_out_valid", 32'(out_valid), 32'd1);
    got = enc; gotCode = err_code;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_out_valid", 32'(out_valid), 32'd0);
    check("post_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  logic [24:0] g;
  logic [1:0]  c;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_enc", 32'(enc), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send(32'd54, 3'd0, 5'd9, 5'd11, 5'd27, 3'd5, 0, g, c);
    check("I_lit", 32'(g), 32'(25'b0000001101100101110101001));
    check("I_code", 32'(c), 32'd0);
    send(32'd54, 3'd1, 5'd9, 5'd11, 5'd27, 3'd5, 0, g, c);
    check("S_lit", 32'(g), 32'(25'b0000001110110101110110110));
    send(32'd54, 3'd2, 5'd9, 5'd11, 5'd27, 3'd5, 0, g, c);
    check("B_lit", 32'(g), 32'(25'b0000001110110101110110110));
    check("B_code", 32'(c), 32'd0);
    send(32'h00036000, 3'd3, 5'd9, 5'd11, 5'd27, 3'd5, 0, g, c);
    check("U_lit", 32'(g), 32'(25'b0000000000000011011001001));
    send(32'd54, 3'd4, 5'd9, 5'd11, 5'd27, 3'd5, 0, g, c);
    check("J_lit", 32'(g), 32'(25'b0000001101100000000001001));

    send(32'd2048, 3'd0, 5'd9, 5'd11, 5'd27, 3'd5, 0, g, c);
    check("I_range_code", 32'(c), 32'd1);
    check("I_range_enc", 32'(g), 32'd0);
    send(32'd55, 3'd2, 5'd9, 5'd11, 5'd27, 3'd5, 0, g, c);
    check("B_misal_code", 32'(c), 32'd2);
    send(32'd55, 3'd7, 5'd9, 5'd11, 5'd27, 3'd5, 0, g, c);
    check("illegal_code", 32'(c), 32'd3);
    check("err_cnt_3", 32'(err_cnt), 32'd3);

    // Format boundaries; the compare process checks each against the model.
    send(32'd2047,        3'd0, 5'd1,  5'd2,  5'd3,  3'd1, 0, g, c);
    send(-32'sd2048,      3'd1, 5'd4,  5'd5,  5'd6,  3'd2, 0, g, c);
    send(-32'sd2049,      3'd0, 5'd7,  5'd8,  5'd9,  3'd3, 0, g, c);
    send(32'd4094,        3'd2, 5'd10, 5'd31, 5'd1,  3'd7, 0, g, c);
    send(-32'sd4096,      3'd2, 5'd3,  5'd4,  5'd5,  3'd0, 0, g, c);
    send(32'd4096,        3'd2, 5'd3,  5'd4,  5'd5,  3'd0, 0, g, c);
    send(32'hFFF00000,    3'd4, 5'd31, 5'd0,  5'd0,  3'd0, 0, g, c);
    check("J_min_enc", 32'(g), 32'(25'h1000000 | 25'd31));
    send(32'h00100000,    3'd4, 5'd31, 5'd0,  5'd0,  3'd0, 0, g, c);
    send(32'hFFFFF000,    3'd3, 5'd17, 5'd0,  5'd0,  3'd0, 0, g, c);
    send(32'h00000800,    3'd3, 5'd17, 5'd0,  5'd0,  3'd0, 0, g, c);
    send(32'd3,           3'd4, 5'd2,  5'd0,  5'd0,  3'd0, 0, g, c);
    send(32'h80000001,    3'd5, 5'd2,  5'd0,  5'd0,  3'd0, 0, g, c);

    // Backpressure: result must hold while out_ready stays low.
    send(32'hFFFFFABC, 3'd1, 5'd12, 5'd13, 5'd14, 3'd6, 5, g, c);

    // Reset while in CHECK aborts the request.
    imm = 32'd54; ImmSrc = 3'd0; rd = 5'd9; rs1 = 5'd11; funct3 = 3'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; cmpEn = 1'b0;
    rst_n = 1'b0; #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_enc", 32'(enc), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    check("abort_err_code", 32'(err_code), 32'd0);
    check("abort_err_cnt", 32'(err_cnt), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    expCnt = 0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);

    // Saturation of the error counter.
    for (int k = 0; k < 300; k++) begin
      case (k % 3)
        0:       send(32'd55,        3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 0, g, c);
        1:       send(32'd55,        3'd2, 5'd1, 5'd1, 5'd1, 3'd0, 0, g, c);
        default: send(32'h10000000,  3'd0, 5'd1, 5'd1, 5'd1, 3'd0, 0, g, c);
      endcase
    end
    check("err_cnt_sat", 32'(err_cnt), 32'd255);
    send(32'd100, 3'd0, 5'd1, 5'd2, 5'd3, 3'd4, 0, g, c);
    check("err_cnt_after_ok", 32'(err_cnt), 32'd255);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
